ram_dp_stream_fifo: RTL and testbench
=====================================

Name: ram_dp_stream_fifo

Overview:
- Valid/ready streaming FIFO controller that owns one true dual-port generic RAM instance and drives its port pins directly.
- Port B of the RAM is the write port; port A is the read port.
- Hides the RAM's active-low enables, its 1- or 2-cycle read latency and its read/write collision hazard behind a plain stream interface.
- Used between activation producers and PE-array consumers.

Parameters:
- AddrWidth, 6, RAM depth in clog2; must match the attached RAM.
- DataWidth, 8, word width; must match the attached RAM.
- Pipelined, 0, must match the attached RAM; read latency L = 1 + Pipelined.

Ports:
- clk  in  1  single clock; drives both RAM clocks.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts a word this cycle.
- in_data  in  DataWidth  write word.
- out_valid  out  1  output word available.
- out_ready  in  1  consumer takes the word.
- out_data  out  DataWidth  head word.
- count  out  AddrWidth+2  total words held (RAM + in flight + output buffer).
- mem_cenA  out  1  active-low RAM read enable.
- mem_aA  out  AddrWidth  RAM read address.
- mem_cenB  out  1  active-low RAM write enable.
- mem_aB  out  AddrWidth  RAM write address.
- mem_d  out  DataWidth  RAM write data.
- mem_bw  out  DataWidth  RAM bit-write mask; constant all ones.
- mem_q  in  DataWidth  RAM read data.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, mem_count=0, inflight=0, output buffer empty, credits=L+1.
  - out_valid=0, count=0, in_ready=0 while rst=1.
  - mem_cenA=1, mem_cenB=1.
  - Reset mid-transfer discards all contents; in_ready returns to 1 in the first cycle after deassertion.
- Write path:
  - in_ready = (mem_count != 2**AddrWidth) && !rst.
  - On in_valid && in_ready, combinationally drive mem_cenB=0, mem_aB=wr_ptr, mem_d=in_data.
  - wr_ptr increments mod 2**AddrWidth.
  - mem_cenB=1 in every other cycle.
- Read issue:
  - issue = (mem_count != 0) && (credits_eff != 0).
  - credits_eff = credits + (out_valid && out_ready), i.e. a credit freed by a pop is usable in the same cycle.
  - On issue, drive mem_cenA=0, mem_aA=rd_ptr; rd_ptr increments mod 2**AddrWidth.
  - mem_cenA=1 when not issuing.
- Collision freedom (by construction):
  - A read is issued only when mem_count>0, where mem_count is the registered value before this cycle's write. This guarantees rd_ptr != wr_ptr for any same-cycle write.
  - At full, the write is blocked.
  - The RAM collision error must never fire; the bench asserts this.
- Return path:
  - An L-deep valid shift register tracks issued reads.
  - When its tail bit is set, mem_q is sampled (same cycle, combinational q) into the output buffer at that clock edge.
  - Output buffer: FIFO of L+1 entries, registered. out_data = head entry; out_valid = buffer non-empty.
  - Pop on out_valid && out_ready frees one credit.
  - Credits are never exceeded, so the buffer never overflows; the bench asserts this.
- Counters:
  - mem_count' = mem_count + push − issue.
  - credits' = credits − issue + pop.
  - count = mem_count + inflight + buffer occupancy; combinational from registers. Maximum value 2**AddrWidth + L + 1.
- Latency: a word pushed into an empty FIFO in cycle 0 is issued in cycle 1, lands in cycle 1+L, and shows out_valid=1 in cycle 2+L (cycle 3 for Pipelined=0, cycle 4 for Pipelined=1).
- Throughput: sustained 1 word/cycle in and out simultaneously once primed, with out_ready held high.
- Wrap-around: pointers wrap silently; ordering is strictly FIFO across the wrap.
- Back-pressure: out_ready=0 stalls reads after at most L+1 buffered words. The RAM then fills to 2**AddrWidth and in_ready drops to 0 in that cycle.
- Simultaneous push and pop at full RAM: the pop frees a buffer slot, which permits an issue. mem_count decrements next cycle; the push is not accepted this cycle (in_ready uses registered mem_count).

Test Plan:
1. Reset, Pipelined=0: push 0xA5 in cycle 0 → mem_cenB=0 with mem_aB=0 in cycle 0; mem_cenA=0 with mem_aA=0 in cycle 1; out_valid=1 with out_data=0xA5 in cycle 3; count=1 from cycle 1.
2. Same as 1 with Pipelined=1 → out_valid in cycle 4; mem_cenA=0 exactly once.
3. Stream 200 incrementing bytes with out_ready=1, AddrWidth=6 → output matches input in order across three pointer wraps; after priming, in_ready and out_valid are high every cycle.
4. out_ready=0, push continuously → in_ready falls after 64+L+1 accepted words; count=66 (Pipelined=0); then out_ready=1 → all 66 words drain in order; count reaches 0.
5. Full FIFO, in_valid=1 and out_ready=1 held for 10 cycles → no RAM collision, no buffer overflow, accepted words interleave correctly.
6. Assert rst for 1 cycle with 20 words stored → out_valid=0 and count=0 immediately; in_ready=1 in the next cycle; a new word 0x3C is output 2+L cycles after its push.

Source files
------------

// File: rtl/ram_dp_stream_fifo_if.sv
// Valid/ready stream bundle for ram_dp_stream_fifo: a producer side, a consumer side and
// the occupancy count.
interface ram_dp_stream_fifo_if #(
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DataWidth-1:0] out_data;
  logic [AddrWidth+1:0] count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/ram_dp_stream_fifo.sv
// Stream FIFO controller around an external true dual-port RAM (port B writes, port A reads).
// Credit-limited read issue keeps the small output buffer from ever overflowing.
module ram_dp_stream_fifo #(
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Pipelined = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_dp_stream_fifo_if.slave  strm,
  output logic                 mem_cenA,
  output logic [AddrWidth-1:0] mem_aA,
  output logic                 mem_cenB,
  output logic [AddrWidth-1:0] mem_aB,
  output logic [DataWidth-1:0] mem_d,
  output logic [DataWidth-1:0] mem_bw,
  input  logic [DataWidth-1:0] mem_q
);

  localparam int unsigned Lat      = 1 + Pipelined;
  localparam int unsigned BufDepth = Lat + 1;
  localparam int unsigned BufPtrW  = $clog2(BufDepth);
  localparam int unsigned OccW     = $clog2(BufDepth + 1);
  localparam int unsigned MemCntW  = AddrWidth + 1;
  localparam int unsigned CntW     = AddrWidth + 2;
  localparam logic [MemCntW-1:0] MemFull = MemCntW'(1) << AddrWidth;

  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [MemCntW-1:0]   mem_count_q, mem_count_d;
  logic [OccW-1:0]      credits_q, credits_d;
  logic [Lat-1:0]       rsp_sr_q, rsp_sr_d;
  logic [BufPtrW-1:0]   buf_wr_q, buf_wr_d;
  logic [BufPtrW-1:0]   buf_rd_q, buf_rd_d;
  logic [OccW-1:0]      buf_occ_q, buf_occ_d;
  logic [DataWidth-1:0] buf_mem_q [BufDepth];

  logic            push;
  logic            pop;
  logic            issue;
  logic            land;
  logic [OccW:0]   credits_eff;
  logic [OccW-1:0] inflight;

  function automatic logic [BufPtrW-1:0] buf_ptr_inc(input logic [BufPtrW-1:0] p);
    return (p == BufPtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign strm.in_ready = (mem_count_q != MemFull) && !rst;
  assign push          = strm.in_valid && strm.in_ready;
  assign pop           = strm.out_valid && strm.out_ready;

  // A slot freed by this cycle's pop may be spent on a read issued in the same cycle.
  assign credits_eff = {1'b0, credits_q} + {{OccW{1'b0}}, pop};
  // Registered mem_count > 0 means rd_ptr never equals the wr_ptr being written now.
  assign issue       = (mem_count_q != '0) && (credits_eff != '0);
  assign land        = rsp_sr_q[Lat-1];

  assign mem_cenB = !push;
  assign mem_aB   = wr_ptr_q;
  assign mem_d    = strm.in_data;
  assign mem_bw   = '1;
  assign mem_cenA = !issue;
  assign mem_aA   = rd_ptr_q;

  assign strm.out_valid = (buf_occ_q != '0);
  assign strm.out_data  = buf_mem_q[buf_rd_q];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < Lat; i++) begin
      inflight = inflight + OccW'(rsp_sr_q[i]);
    end
  end

  assign strm.count = CntW'(mem_count_q) + CntW'(inflight) + CntW'(buf_occ_q);

  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_count_d = mem_count_q + MemCntW'(push) - MemCntW'(issue);
    credits_d   = credits_q - OccW'(issue) + OccW'(pop);
    rsp_sr_d    = (rsp_sr_q << 1) | Lat'(issue);
    buf_wr_d    = land ? buf_ptr_inc(buf_wr_q) : buf_wr_q;
    buf_rd_d    = pop  ? buf_ptr_inc(buf_rd_q) : buf_rd_q;
    buf_occ_d   = buf_occ_q + OccW'(land) - OccW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      credits_q   <= OccW'(BufDepth);
      rsp_sr_q    <= '0;
      buf_wr_q    <= '0;
      buf_rd_q    <= '0;
      buf_occ_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      credits_q   <= credits_d;
      rsp_sr_q    <= rsp_sr_d;
      buf_wr_q    <= buf_wr_d;
      buf_rd_q    <= buf_rd_d;
      buf_occ_q   <= buf_occ_d;
    end
  end

  // RAM read data is only valid in the cycle the response tail bit is set.
  always_ff @(posedge clk) begin
    if (land) begin
      buf_mem_q[buf_wr_q] <= mem_q;
    end
  end

endmodule

// File: tb/tb_ram_dp_stream_fifo.sv
// Bench for ram_dp_stream_fifo: Pipelined=0 and Pipelined=1 instances share one stimulus,
// each with its own RAM model and expected-data scoreboard.
module tb_ram_dp_stream_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [1:0] in_ready, out_valid, cen_a, cen_b;
  logic [7:0] out_data [2];
  logic [7:0] count    [2];
  logic [5:0] a_a      [2];
  logic [5:0] a_b      [2];
  logic [7:0] mem_d    [2];
  logic [7:0] mem_bw   [2];
  logic [7:0] mem_q    [2];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];

  int first_valid [2];
  int reads       [2];
  int acc         [2];
  int gaps_in     [2];
  int gaps_out    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    ram_dp_stream_fifo_if #(.AddrWidth(6), .DataWidth(8)) sif ();
    logic [7:0] ram [64];
    logic [7:0] q1, q2;

    assign sif.in_valid  = in_valid;
    assign sif.in_data   = in_data;
    assign sif.out_ready = out_ready;
    assign in_ready[g]   = sif.in_ready;
    assign out_valid[g]  = sif.out_valid;
    assign out_data[g]   = sif.out_data;
    assign count[g]      = sif.count;

    ram_dp_stream_fifo #(.AddrWidth(6), .DataWidth(8), .Pipelined(g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .strm     (sif),
      .mem_cenA (cen_a[g]),
      .mem_aA   (a_a[g]),
      .mem_cenB (cen_b[g]),
      .mem_aB   (a_b[g]),
      .mem_d    (mem_d[g]),
      .mem_bw   (mem_bw[g]),
      .mem_q    (mem_q[g])
    );

    always @(posedge clk) begin
      if (!cen_b[g]) ram[a_b[g]] <= (ram[a_b[g]] & ~mem_bw[g]) | (mem_d[g] & mem_bw[g]);
      if (!cen_a[g]) q1 <= ram[a_a[g]];
      q2 <= q1;
    end
    assign mem_q[g] = (g == 0) ? q1 : q2;
  end

  function automatic void check(string name, int g, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [P%0d]: got 0x%0h, expected 0x%0h", name, g, act, exp);
    end
  endfunction

  function automatic int exp_size(int g);
    return (g == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: records accepted words, compares every output handshake, watches hazards.
  task automatic monitor();
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int g = 0; g < 2; g++) begin
          if (out_valid[g] && out_ready) begin
            if (exp_size(g) == 0) begin
              check("unexpected out_valid", g, 32'(out_data[g]), 32'hFFFF_FFFF);
            end else begin
              if (g == 0) v = exp0.pop_front();
              else        v = exp1.pop_front();
              check("out_data", g, 32'(out_data[g]), 32'(v));
            end
          end
          if (in_valid && in_ready[g]) begin
            if (g == 0) exp0.push_back(in_data);
            else        exp1.push_back(in_data);
          end
          if (!cen_a[g] && !cen_b[g] && (a_a[g] == a_b[g])) begin
            n_err++;
            $display("FAIL ram collision [P%0d]: addr 0x%0h read and written, required never",
                     g, a_a[g]);
          end
          if (32'(count[g]) > 32'(66 + g)) begin
            n_err++;
            $display("FAIL count bound [P%0d]: got %0d, required <= %0d", g, count[g], 66 + g);
          end
        end
      end
    end
  endtask

  task automatic run();
    // Reset state
    repeat (2) next();
    mid();
    for (int g = 0; g < 2; g++) begin
      check("rst in_ready", g, 32'(in_ready[g]), 0);
      check("rst out_valid", g, 32'(out_valid[g]), 0);
      check("rst count", g, 32'(count[g]), 0);
      check("rst cenA", g, 32'(cen_a[g]), 1);
      check("rst cenB", g, 32'(cen_b[g]), 1);
      check("mem_bw", g, 32'(mem_bw[g]), 32'hFF);
    end
    next();
    rst = 1'b0;
    mid();
    for (int g = 0; g < 2; g++) check("in_ready after rst", g, 32'(in_ready[g]), 1);

    // Single word latency
    next();
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    mid();
    for (int g = 0; g < 2; g++) begin
      check("c0 cenB", g, 32'(cen_b[g]), 0);
      check("c0 aB", g, 32'(a_b[g]), 0);
      check("c0 count", g, 32'(count[g]), 0);
      first_valid[g] = -1;
      reads[g] = 0;
    end
    next();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      mid();
      for (int g = 0; g < 2; g++) begin
        if (!cen_a[g]) reads[g]++;
        if (c == 1) begin
          check("c1 cenA", g, 32'(cen_a[g]), 0);
          check("c1 aA", g, 32'(a_a[g]), 0);
        end
        if (c <= 3 + g) check("single word count", g, 32'(count[g]), 1);
        if (out_valid[g] && first_valid[g] < 0) first_valid[g] = c;
      end
      next();
    end
    for (int g = 0; g < 2; g++) begin
      check("first out_valid cycle", g, 32'(first_valid[g]), 32'(3 + g));
      check("read issue count", g, 32'(reads[g]), 1);
      check("count after single", g, 32'(count[g]), 0);
    end

    // 200-word stream through three pointer wraps
    for (int g = 0; g < 2; g++) begin
      gaps_in[g]  = 0;
      gaps_out[g] = 0;
    end
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      mid();
      for (int g = 0; g < 2; g++) begin
        if (!in_ready[g]) gaps_in[g]++;
        if (i >= 3 + g && !out_valid[g]) gaps_out[g]++;
      end
      next();
    end
    in_valid = 1'b0;
    repeat (8) next();
    mid();
    for (int g = 0; g < 2; g++) begin
      check("stream in_ready gaps", g, 32'(gaps_in[g]), 0);
      check("stream out_valid gaps", g, 32'(gaps_out[g]), 0);
      check("stream drained count", g, 32'(count[g]), 0);
      check("stream queue empty", g, 32'(exp_size(g)), 0);
    end

    // Back-pressure until full
    next();
    out_ready = 1'b0;
    for (int g = 0; g < 2; g++) acc[g] = 0;
    for (int c = 0; c < 80; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(c + 100);
      mid();
      for (int g = 0; g < 2; g++) if (in_ready[g]) acc[g]++;
      next();
    end
    mid();
    for (int g = 0; g < 2; g++) begin
      check("full accepted words", g, 32'(acc[g]), 32'(66 + g));
      check("full count", g, 32'(count[g]), 32'(66 + g));
      check("full in_ready", g, 32'(in_ready[g]), 0);
      check("full cenB", g, 32'(cen_b[g]), 1);
    end

    // Push and pop held at full
    next();
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++) acc[g] = 0;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'(c + 200);
      mid();
      for (int g = 0; g < 2; g++) if (in_ready[g]) acc[g]++;
      next();
    end
    in_valid = 1'b0;
    for (int g = 0; g < 2; g++) check("full push+pop accepted", g, 32'(acc[g]), 9);
    for (int c = 0; c < 300; c++) begin
      mid();
      if (count[0] == 8'd0 && count[1] == 8'd0) break;
      next();
    end
    for (int g = 0; g < 2; g++) begin
      check("drain count", g, 32'(count[g]), 0);
      check("drain queue empty", g, 32'(exp_size(g)), 0);
    end

    // Reset with 20 words stored
    next();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 8'h50);
      next();
    end
    in_valid = 1'b0;
    repeat (3) next();
    mid();
    for (int g = 0; g < 2; g++) check("stored count", g, 32'(count[g]), 20);
    next();
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("mid rst out_valid", g, 32'(out_valid[g]), 0);
      check("mid rst count", g, 32'(count[g]), 0);
      check("mid rst in_ready", g, 32'(in_ready[g]), 0);
    end
    exp0.delete();
    exp1.delete();
    next();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    mid();
    for (int g = 0; g < 2; g++) begin
      check("post rst in_ready", g, 32'(in_ready[g]), 1);
      first_valid[g] = -1;
    end
    next();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      mid();
      for (int g = 0; g < 2; g++) if (out_valid[g] && first_valid[g] < 0) first_valid[g] = c;
      next();
    end
    for (int g = 0; g < 2; g++) begin
      check("post rst latency", g, 32'(first_valid[g]), 32'(3 + g));
      check("post rst queue empty", g, 32'(exp_size(g)), 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    fork
      monitor();
      run();
      begin
        #500000;
        n_err++;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
